// File: rtl/tdc_ram_readout.sv
// tdc_ram_readout: streams 16-bit TDC result words from a sync-read RAM to a byte host
// interface, MSB first. Define TDC_READOUT_CHECKSUM_EN to append an XOR checksum byte.
module tdc_ram_readout #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   n_words,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [15:0]       ram_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  // Byte handshake: a byte moves on a rising edge with tx_valid && tx_ready. While
  // tx_valid=1 and tx_ready=0, tx_data is held and tx_valid stays up (abort/reset excepted).
`ifdef TDC_READOUT_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_SEND_HI, S_SEND_LO, S_DONE, S_CSUM} state_t;
  localparam state_t LAST_NEXT = S_CSUM;
  logic [7:0] csum_q;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_SEND_HI, S_SEND_LO, S_DONE} state_t;
  localparam state_t LAST_NEXT = S_DONE;
`endif

  localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   WORD_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remain_q;
  logic [ADDR_W:0]   n_clamped;
  logic [15:0]       word_q;
  logic              xfer;

  assign n_clamped = (n_words > MAX_WORDS) ? MAX_WORDS : n_words;
  assign xfer      = tx_valid && tx_ready;
  assign ram_addr  = addr_q;

  always_comb begin
    state_next = state;
    ram_rd     = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: if (start) state_next = (n_clamped == '0) ? LAST_NEXT : S_READ;
      S_READ: begin
        ram_rd     = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: state_next = S_SEND_HI;
      S_SEND_HI: begin
        tx_valid = 1'b1;
        tx_data  = word_q[15:8];
        if (tx_ready) state_next = S_SEND_LO;
      end
      S_SEND_LO: begin
        tx_valid = 1'b1;
        tx_data  = word_q[7:0];
        if (tx_ready) state_next = (remain_q == WORD_ONE) ? LAST_NEXT : S_READ;
      end
`ifdef TDC_READOUT_CHECKSUM_EN
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (tx_ready) state_next = S_DONE;
      end
`endif
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Abort wins over any transfer in flight; start wins over abort in IDLE.
    if (abort && state != S_IDLE) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      word_q   <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && start) begin
        addr_q   <= start_addr;
        remain_q <= n_clamped;
      end
      if (state == S_WAIT) word_q <= ram_rdata;
      if (state == S_SEND_LO && xfer) begin
        addr_q   <= addr_q + ADDR_ONE;
        remain_q <= remain_q - WORD_ONE;
      end
    end
  end

`ifdef TDC_READOUT_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= 8'h00;
    end else if (state == S_IDLE && start) begin
      csum_q <= 8'h00;
    end else if (xfer && (state == S_SEND_HI || state == S_SEND_LO)) begin
      csum_q <= csum_q ^ tx_data;
    end
  end
`endif

endmodule

// File: tb/tb_tdc_ram_readout.sv
// tb_tdc_ram_readout: directed bench for tdc_ram_readout with a behavioural sync-read RAM.
// Honours TDC_READOUT_CHECKSUM_EN to expect the trailing checksum byte.
module tb_tdc_ram_readout;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef TDC_READOUT_CHECKSUM_EN
  localparam int CSUM_EXTRA = 1;
`else
  localparam int CSUM_EXTRA = 0;
`endif

  logic              clk, reset_n, start, abort, tx_ready;
  logic [ADDR_W-1:0] start_addr, ram_addr;
  logic [ADDR_W:0]   n_words;
  logic              ram_rd, tx_valid, busy, done;
  logic [15:0]       ram_rdata;
  logic [7:0]        tx_data;

  logic [15:0]       mem [DEPTH];
  logic [15:0]       words_t1 [8] = '{16'h1234, 16'hABCD, 16'h5678, 16'h9ABC,
                                      16'hDEF0, 16'h2468, 16'h1357, 16'hCAFE};
  logic [7:0]        exp_q[$];
  logic [7:0]        got_q[$];
  logic [ADDR_W-1:0] rd_q[$];
  int                n_checks, n_errors, start_cyc, done_cnt, done_cyc;
  int                cyc = 0;

  tdc_ram_readout #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .start_addr(start_addr), .n_words(n_words),
    .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  // Clock, cycle counter and RAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_rd) ram_rdata <= mem[ram_addr];

  // Monitor: sampled on the falling edge, between driver updates and active edges
  always @(negedge clk) begin
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    if (ram_rd) rd_q.push_back(ram_addr);
    if (done) begin
      done_cnt++;
      done_cyc = cyc - start_cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic push_csum();
`ifdef TDC_READOUT_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
`endif
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  // Drives start for cycle 0 of a readout; returns just after the edge that ends it.
  task automatic start_readout(input logic [ADDR_W-1:0] sa, input logic [ADDR_W:0] nw);
    @(posedge clk); #1;
    got_q.delete(); exp_q.delete(); rd_q.delete();
    done_cnt   = 0;
    done_cyc   = -1;
    start      = 1'b1;
    start_addr = sa;
    n_words    = nw;
    start_cyc  = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; done_cnt = 0; done_cyc = -1; start_cyc = 0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
    start_addr = '0; n_words = '0; ram_rdata = 16'h0000;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) mem[i] = words_t1[i];

    #3;
    check("rst_outputs", {ram_rd, tx_valid, busy, done}, 4'b0000);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_tx_data", tx_data, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Eight-word run; a start pulse with other parameters while busy must be ignored
    start_readout(0, 8);
    for (int i = 0; i < 8; i++) push_word(words_t1[i]);
    push_csum();
    @(posedge clk); #1;
    start = 1'b1; start_addr = 100; n_words = 1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("run8", 200);
    check_bytes("run8");
    check("run8_rd_count", rd_q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < rd_q.size()) check($sformatf("run8_addr%0d", i), rd_q[i], i);
    check("run8_done_cycle", done_cyc, 33 + CSUM_EXTRA);
    check("run8_done_count", done_cnt, 1);

    // Zero-length readout
    start_readout(0, 0);
    push_csum();
    wait_idle("zero", 20);
    check_bytes("zero");
    check("zero_rd_count", rd_q.size(), 0);
    check("zero_done_cycle", done_cyc, 1 + CSUM_EXTRA);

    // Abort during the low byte of the third word (cycle 12)
    start_readout(0, 8);
    for (int i = 0; i < 3; i++) push_word(words_t1[i]);
    repeat (11) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    check("abort_lo_valid", tx_valid, 1'b1);
    check("abort_lo_data", tx_data, 8'h78);
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_after", {tx_valid, ram_rd, busy}, 3'b000);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check_bytes("abort");
    start_readout(5, 1);
    push_word(16'h2468);
    push_csum();
    wait_idle("post_abort", 50);
    check_bytes("post_abort");
    check("post_abort_done", done_cnt, 1);

    // Back-pressure: tx_ready low for cycles 0..7, i.e. five cycles of SEND_HI
    mem[16] = 16'h55AA;
    tx_ready = 1'b0;
    start_readout(16, 1);
    push_word(16'h55AA);
    push_csum();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check($sformatf("stall_valid_c%0d", k + 1), tx_valid, 1'b1);
        check($sformatf("stall_data_c%0d", k + 1), tx_data, 8'h55);
      end
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_idle("stall", 50);
    check_bytes("stall");
    check("stall_rd_count", rd_q.size(), 1);

    // Address wrap-around
    mem[DEPTH-1] = 16'hBEEF;
    mem[0]       = 16'h0102;
    start_readout(ADDR_W'(DEPTH - 1), 2);
    push_word(16'hBEEF);
    push_word(16'h0102);
    push_csum();
    wait_idle("wrap", 50);
    check_bytes("wrap");
    check("wrap_rd_count", rd_q.size(), 2);
    if (rd_q.size() == 2) begin
      check("wrap_addr0", rd_q[0], DEPTH - 1);
      check("wrap_addr1", rd_q[1], 0);
    end

    // Oversized n_words clamps to the RAM depth
    start_readout(0, 11'h7FF);
    wait_idle("clamp", 5000);
    check("clamp_byte_count", got_q.size(), 2 * DEPTH + CSUM_EXTRA);
    check("clamp_rd_count", rd_q.size(), DEPTH);
    check("clamp_done_cycle", done_cyc, 4 * DEPTH + 1 + CSUM_EXTRA);

    // Asynchronous reset in the middle of a transfer
    start_readout(0, 8);
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_outputs", {ram_rd, tx_valid, busy, done}, 4'b0000);
    check("arst_ram_addr", ram_addr, 0);
    check("arst_tx_data", tx_data, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("arst_no_done", done_cnt, 0);
    mem[20] = 16'h1234;
    mem[21] = 16'h5678;
    start_readout(20, 2);
    push_word(16'h1234);
    push_word(16'h5678);
`ifdef TDC_READOUT_CHECKSUM_EN
    exp_q.push_back(8'h08);
`endif
    wait_idle("post_rst", 50);
    check_bytes("post_rst");
    check("post_rst_done_cycle", done_cyc, 9 + CSUM_EXTRA);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tdc_ram_readout.md
Name: tdc_ram_readout

Overview:
- Reads the TDC result words that the TDC sequencer stores in the base-board RAM and streams them to the host byte interface.
- Memory is read through a single-port synchronous-read RAM port; each 16-bit word is sent as two bytes, MSB first, over a valid/ready byte handshake.
- Sits between the result RAM and the host interface FIFO. A single TDC_V1_SW_28_10_19 run produces 8 words (4 TDCs x 2 words).

Parameters:
ADDR_W, 10, RAM address width; the RAM holds 2^ADDR_W words of 16 bits.

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  begin a readout; sampled only in IDLE
abort  input  1  synchronous abort of a running readout
start_addr  input  ADDR_W  first RAM address to read
n_words  input  ADDR_W+1  number of 16-bit words to send
ram_rd  output  1  RAM read enable
ram_addr  output  ADDR_W  RAM read address
ram_rdata  input  16  RAM read data, valid 1 cycle after ram_rd
tx_data  output  8  byte to the host interface
tx_valid  output  1  tx_data is valid
tx_ready  input  1  host interface accepts a byte
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a readout completes normally

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - ram_rd=0, ram_addr=0, tx_data=0, tx_valid=0, busy=0, done=0.
  - Internal word register, address counter, remaining-word counter and checksum are all cleared.
  - Reset asserted mid-readout discards the transfer; no done pulse.
- Byte handshake:
  - A byte transfers on a rising edge where tx_valid=1 and tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_data holds stable.
  - tx_valid never drops without a transfer, except on abort or reset.
- States:
  - IDLE: on start=1, latch start_addr into the address counter and n_words into the remaining counter. If n_words=0, go to DONE; otherwise go to READ. n_words greater than 2^ADDR_W is clamped to 2^ADDR_W.
  - READ: ram_rd=1 for exactly one cycle with ram_addr = address counter. Go to WAIT.
  - WAIT: ram_rd=0. Capture ram_rdata into the word register at the end of this cycle. Go to SEND_HI.
  - SEND_HI: tx_valid=1, tx_data = word[15:8]. On transfer, go to SEND_LO.
  - SEND_LO: tx_data = word[7:0]. On transfer, increment the address modulo 2^ADDR_W and decrement the remaining counter. If remaining becomes 0, go to DONE (or CSUM when the optional feature is built); otherwise go to READ.
  - DONE: done=1 for one cycle, tx_valid=0. Go to IDLE.
- Handshake between the two bytes of a word:
  - tx_valid stays high from SEND_HI into SEND_LO, so back-to-back bytes are possible.
  - tx_valid drops for the two cycles READ+WAIT between words.
- Latency, with tx_ready held high:
  - start sampled at cycle 0; ram_rd at cycle 1; first tx_valid at cycle 3.
  - Each word takes 4 cycles, so N words take 4N cycles plus 1 cycle for DONE.
- Address wrap-around: start_addr=2^ADDR_W-1 with n_words=2 reads addresses 2^ADDR_W-1 then 0.
- start while busy is ignored; parameters are latched only in IDLE.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; tx_valid and ram_rd are 0 the following cycle; no done pulse.
  - abort has priority over a simultaneous transfer; the byte counts as sent but no further bytes follow.
- abort in IDLE is ignored. If start and abort are both high in IDLE, start wins.

Optional Feature:
- Macro: TDC_READOUT_CHECKSUM_EN.
- Defined:
  - An 8-bit checksum register is cleared at start and XOR-updated with every transferred byte.
  - After the last SEND_LO transfer, the block enters CSUM: tx_valid=1, tx_data = checksum.
  - On transfer it goes to DONE.
  - With n_words=0 the block still sends one checksum byte, 0x00.
  - Abort behaviour is unchanged.
- Not defined: no CSUM state and no checksum logic; SEND_LO goes directly to DONE.

Test Plan:
- RAM[0..7] = 0x1234, 0xABCD, ... ; start_addr=0, n_words=8, tx_ready=1 -> bytes 0x12, 0x34, 0xAB, 0xCD, ... (16 bytes, in order); ram_addr sequence 0..7; done pulse at cycle 33; busy low after it.
- n_words=0 -> no tx_valid, done at cycle 1 (checksum build: one byte 0x00, then done).
- start_addr=2^ADDR_W-1, n_words=2, RAM[last]=0xBEEF, RAM[0]=0x0102 -> bytes 0xBE, 0xEF, 0x01, 0x02.
- tx_ready low for 5 cycles during SEND_HI of word 0x55AA -> tx_data holds 0x55 throughout; no duplicated or dropped bytes; ram_rd is not re-asserted.
- abort during the SEND_LO of word 3 of 8 -> tx_valid=0 next cycle, busy=0, no done; a following start with n_words=1 reads a single word correctly.
- reset_n pulsed low mid-transfer -> all outputs 0 immediately (asynchronously); a start after release behaves normally. Checksum build: words 0x1234, 0x5678 -> trailing byte 0x08.
